mdio_master: RTL and testbench

- Parametrised MDIO/SMI management master: the next-generation replacement for the fixed VSC8541 MDC generator and MDIO pair.
- Supports IEEE 802.3 Clause 22 and Clause 45 frames, configurable preamble length, and an internally gated MDC.
- On reads, checks the turnaround (TA) bit and flags absent or non-responding PHYs.
- Sits between the register block (mode/address/data fields, start pulse, read-only response registers) and the board MDC/MDIO pins; the top level builds the inout from o_mdio_out/o_mdio_oe/i_mdio_in.

---
 rtl/mdio_pkg.sv | 43 ++++
 rtl/mdio_mdc_gen.sv | 51 +++++
 rtl/mdio_master.sv | 236 +++++++++++++++++++++++
 tb/tb_mdio_master.sv | 216 +++++++++++++++++++++
 4 files changed

// File: rtl/mdio_pkg.sv
// mdio_pkg: shared types and constants for the MDIO management master.
//   mdio_state_t : frame sequencer states
//   ST_* / OP*   : start-of-frame and opcode field values for Clause 22/45
//   is_read()    : classifies a (clause, op) pair as a read-type frame
package mdio_pkg;

  typedef enum logic [2:0] {
    IDLE,
    PRE,
    HDR,
    TA,
    DATA,
    GAP
  } mdio_state_t;

  localparam logic [1:0] ST_C22       = 2'b01;
  localparam logic [1:0] ST_C45       = 2'b00;

  localparam logic [1:0] OP22_WRITE   = 2'b01;
  localparam logic [1:0] OP22_READ    = 2'b10;

  localparam logic [1:0] OP45_ADDR    = 2'b00;
  localparam logic [1:0] OP45_WRITE   = 2'b01;
  localparam logic [1:0] OP45_READ    = 2'b11;
  localparam logic [1:0] OP45_PRD_INC = 2'b10;

  // TA pattern the master drives on write-type frames
  localparam logic [1:0] TA_WRITE     = 2'b10;

  localparam int HDR_BITS  = 14;
  localparam int TA_BITS   = 2;
  localparam int DATA_BITS = 16;

  // Any opcode that is not a read is executed as a write-type frame,
  // including the illegal Clause 22 codes.
  function automatic logic is_read(input logic clause45, input logic [1:0] op);
    if (clause45) begin
      return (op == OP45_READ) || (op == OP45_PRD_INC);
    end
    return (op == OP22_READ);
  endfunction

endpackage

// File: rtl/mdio_mdc_gen.sv
// mdio_mdc_gen: gated MDC divider.
//   clk        : system clock
//   i_reset_n  : async active-low reset
//   i_en       : run the divider; when low MDC is parked low and the phase restarts
//   o_mdc      : management clock, MDC_DIVISOR/2 cycles low then high
//   o_rise_stb : high in the cycle whose closing edge drives MDC high
//   o_fall_stb : high in the cycle whose closing edge drives MDC low
module mdio_mdc_gen
  import mdio_pkg::*;
#(
  parameter int MDC_DIVISOR = 50
) (
  input  logic clk,
  input  logic i_reset_n,
  input  logic i_en,
  output logic o_mdc,
  output logic o_rise_stb,
  output logic o_fall_stb
);

  localparam int HALF = MDC_DIVISOR / 2;
  localparam int CW   = (HALF > 1) ? $clog2(HALF) : 1;
  localparam logic [CW-1:0] HALF_LOAD = CW'(HALF - 1);

  logic [CW-1:0] r_cnt;
  logic          r_mdc;
  logic          w_tc;

  // Strobes lead the MDC edge by one clk so the sequencer can update MDIO
  // on the very edge where MDC toggles.
  assign w_tc       = i_en && (r_cnt == '0);
  assign o_rise_stb = w_tc && !r_mdc;
  assign o_fall_stb = w_tc && r_mdc;
  assign o_mdc      = r_mdc;

  always_ff @(posedge clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      r_cnt <= HALF_LOAD;
      r_mdc <= 1'b0;
    end else if (!i_en) begin
      r_cnt <= HALF_LOAD;
      r_mdc <= 1'b0;
    end else if (w_tc) begin
      r_cnt <= HALF_LOAD;
      r_mdc <= ~r_mdc;
    end else begin
      r_cnt <= r_cnt - 1'b1;
    end
  end

endmodule

// File: rtl/mdio_master.sv
// mdio_master: Clause 22 / Clause 45 MDIO management master.
//   clk, i_reset_n            : system clock, async active-low reset
//   i_start                   : one-cycle request, accepted only when idle
//   i_clause45, i_op          : frame type and raw OP field
//   i_phy_addr, i_reg_addr    : PHYAD/PRTAD and REGAD/DEVAD
//   i_data                    : write data or Clause 45 address
//   o_busy                    : frame in progress (including idle gap)
//   o_dv                      : one-cycle end-of-frame pulse
//   o_data, o_ta_err          : read result and missing-PHY flag
//   o_mdc                     : management clock, low when idle
//   o_mdio_out, o_mdio_oe     : MDIO pin drive value and enable
//   i_mdio_in                 : MDIO pin readback
//
// state | meaning
// IDLE  | waiting for i_start, MDC parked low, MDIO released
// PRE   | driving PREAMBLE_BITS ones
// HDR   | driving ST, OP, PHY, REG (14 bits)
// TA    | turnaround: drive 10 on writes, release and sample on reads
// DATA  | 16 data bits MSB first, driven or sampled
// GAP   | IDLE_BITS MDC periods with MDIO released, then report result
module mdio_master
  import mdio_pkg::*;
#(
  parameter int MDC_DIVISOR   = 50,
  parameter int PREAMBLE_BITS = 32,
  parameter int IDLE_BITS     = 1
) (
  input  logic        clk,
  input  logic        i_reset_n,
  input  logic        i_start,
  input  logic        i_clause45,
  input  logic [1:0]  i_op,
  input  logic [4:0]  i_phy_addr,
  input  logic [4:0]  i_reg_addr,
  input  logic [15:0] i_data,
  output logic        o_busy,
  output logic        o_dv,
  output logic [15:0] o_data,
  output logic        o_ta_err,
  output logic        o_mdc,
  output logic        o_mdio_out,
  output logic        o_mdio_oe,
  input  logic        i_mdio_in
);

  // Counter must hold PREAMBLE_BITS-1 (<= 31) and IDLE_BITS-1.
  localparam int BC_W = (IDLE_BITS > 32) ? $clog2(IDLE_BITS) : 6;
  localparam logic [BC_W-1:0] PRE_LOAD  = BC_W'((PREAMBLE_BITS > 0) ? PREAMBLE_BITS - 1 : 0);
  localparam logic [BC_W-1:0] HDR_LOAD  = BC_W'(HDR_BITS - 1);
  localparam logic [BC_W-1:0] TA_LOAD   = BC_W'(TA_BITS - 1);
  localparam logic [BC_W-1:0] DATA_LOAD = BC_W'(DATA_BITS - 1);
  localparam logic [BC_W-1:0] GAP_LOAD  = BC_W'(IDLE_BITS - 1);

  mdio_state_t     r_state,   w_state_nxt;
  logic [BC_W-1:0] r_bit_cnt, w_bit_cnt_nxt;
  logic [31:0]     r_sr,      w_sr_nxt;
  logic            r_rd,      w_rd_nxt;
  logic [15:0]     r_rx,      w_rx_nxt;
  logic            r_ta_bit,  w_ta_bit_nxt;
  logic            r_mdio_out, w_out_nxt;
  logic            r_mdio_oe,  w_oe_nxt;
  logic            r_dv,       w_dv_nxt;
  logic [15:0]     r_data,     w_data_nxt;
  logic            r_ta_err,   w_err_nxt;
  logic [31:0]     w_sr_shift;
  logic            w_rise_stb;
  logic            w_fall_stb;
  logic            w_mdc_en;

  assign w_mdc_en = (r_state != IDLE);

  mdio_mdc_gen #(
    .MDC_DIVISOR (MDC_DIVISOR)
  ) u_mdc_gen (
    .clk        (clk),
    .i_reset_n  (i_reset_n),
    .i_en       (w_mdc_en),
    .o_mdc      (o_mdc),
    .o_rise_stb (w_rise_stb),
    .o_fall_stb (w_fall_stb)
  );

  always_ff @(posedge clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      r_state    <= IDLE;
      r_bit_cnt  <= '0;
      r_sr       <= '0;
      r_rd       <= 1'b0;
      r_rx       <= '0;
      r_ta_bit   <= 1'b0;
      r_mdio_out <= 1'b1;
      r_mdio_oe  <= 1'b0;
      r_dv       <= 1'b0;
      r_data     <= '0;
      r_ta_err   <= 1'b0;
    end else begin
      r_state    <= w_state_nxt;
      r_bit_cnt  <= w_bit_cnt_nxt;
      r_sr       <= w_sr_nxt;
      r_rd       <= w_rd_nxt;
      r_rx       <= w_rx_nxt;
      r_ta_bit   <= w_ta_bit_nxt;
      r_mdio_out <= w_out_nxt;
      r_mdio_oe  <= w_oe_nxt;
      r_dv       <= w_dv_nxt;
      r_data     <= w_data_nxt;
      r_ta_err   <= w_err_nxt;
    end
  end

  always_comb begin
    w_state_nxt   = r_state;
    w_bit_cnt_nxt = r_bit_cnt;
    w_sr_nxt      = r_sr;
    w_rd_nxt      = r_rd;
    w_rx_nxt      = r_rx;
    w_ta_bit_nxt  = r_ta_bit;
    w_out_nxt     = r_mdio_out;
    w_oe_nxt      = r_mdio_oe;
    w_dv_nxt      = 1'b0;
    w_data_nxt    = r_data;
    w_err_nxt     = r_ta_err;
    w_sr_shift    = {r_sr[30:0], 1'b0};

    // Input side: sample on the MDC rising edge.
    if (w_rise_stb) begin
      if (r_state == TA && r_bit_cnt == '0) w_ta_bit_nxt = i_mdio_in;
      if (r_state == DATA) w_rx_nxt = {r_rx[14:0], i_mdio_in};
    end

    // Output side: the bit register always holds the bit currently on the
    // wire at r_sr[31]; each MDC falling edge shifts the next one in.
    case (r_state)
      IDLE: begin
        if (i_start) begin
          w_sr_nxt = {(i_clause45 ? ST_C45 : ST_C22), i_op, i_phy_addr,
                      i_reg_addr, TA_WRITE, i_data};
          w_rd_nxt = is_read(i_clause45, i_op);
          w_oe_nxt = 1'b1;
          if (PREAMBLE_BITS > 0) begin
            w_state_nxt   = PRE;
            w_bit_cnt_nxt = PRE_LOAD;
            w_out_nxt     = 1'b1;
          end else begin
            w_state_nxt   = HDR;
            w_bit_cnt_nxt = HDR_LOAD;
            w_out_nxt     = w_sr_nxt[31];
          end
        end
      end
      PRE: begin
        if (w_fall_stb) begin
          if (r_bit_cnt == '0) begin
            w_state_nxt   = HDR;
            w_bit_cnt_nxt = HDR_LOAD;
            w_out_nxt     = r_sr[31];
          end else begin
            w_bit_cnt_nxt = r_bit_cnt - 1'b1;
          end
        end
      end
      HDR: begin
        if (w_fall_stb) begin
          w_sr_nxt  = w_sr_shift;
          w_out_nxt = w_sr_shift[31];
          if (r_bit_cnt == '0) begin
            w_state_nxt   = TA;
            w_bit_cnt_nxt = TA_LOAD;
            // Reads hand the line to the PHY for the whole turnaround.
            if (r_rd) begin
              w_oe_nxt  = 1'b0;
              w_out_nxt = 1'b1;
            end
          end else begin
            w_bit_cnt_nxt = r_bit_cnt - 1'b1;
          end
        end
      end
      TA: begin
        if (w_fall_stb) begin
          w_sr_nxt  = w_sr_shift;
          w_out_nxt = r_rd ? 1'b1 : w_sr_shift[31];
          if (r_bit_cnt == '0) begin
            w_state_nxt   = DATA;
            w_bit_cnt_nxt = DATA_LOAD;
          end else begin
            w_bit_cnt_nxt = r_bit_cnt - 1'b1;
          end
        end
      end
      DATA: begin
        if (w_fall_stb) begin
          w_sr_nxt  = w_sr_shift;
          w_out_nxt = r_rd ? 1'b1 : w_sr_shift[31];
          if (r_bit_cnt == '0) begin
            w_state_nxt   = GAP;
            w_bit_cnt_nxt = GAP_LOAD;
            w_oe_nxt      = 1'b0;
            w_out_nxt     = 1'b1;
          end else begin
            w_bit_cnt_nxt = r_bit_cnt - 1'b1;
          end
        end
      end
      GAP: begin
        if (w_fall_stb) begin
          if (r_bit_cnt == '0) begin
            w_state_nxt = IDLE;
            w_dv_nxt    = 1'b1;
            w_err_nxt   = 1'b0;
            if (r_rd) begin
              // A released line reads as 1 through the pull-up: no PHY.
              if (r_ta_bit) begin
                w_data_nxt = 16'hFFFF;
                w_err_nxt  = 1'b1;
              end else begin
                w_data_nxt = r_rx;
              end
            end
          end else begin
            w_bit_cnt_nxt = r_bit_cnt - 1'b1;
          end
        end
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  assign o_busy     = (r_state != IDLE);
  assign o_dv       = r_dv;
  assign o_data     = r_data;
  assign o_ta_err   = r_ta_err;
  assign o_mdio_out = r_mdio_out;
  assign o_mdio_oe  = r_mdio_oe;

endmodule

// File: tb/tb_mdio_master.sv
`timescale 1ns/1ps
module tb_mdio_master;

  localparam int DIV = 4;

  typedef struct {
    bit          sel;        // 0 = DUT A (32-bit preamble), 1 = DUT B (no preamble)
    bit          c45;
    logic [1:0]  op;
    logic [4:0]  phy;
    logic [4:0]  rg;
    logic [15:0] data;
    bit          resp_en;    // behavioural PHY answers
    logic [15:0] resp;
    bit          is_rd;
    logic [31:0] exp_frame;  // ST..DATA as seen on the wire (TA/DATA ignored for reads)
    logic [15:0] exp_data;
    bit          exp_err;
  } vec_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n   = 1'b0;
  logic        start_a = 1'b0;
  logic        start_b = 1'b0;
  logic        c45     = 1'b0;
  logic [1:0]  op      = 2'b00;
  logic [4:0]  phy     = 5'd0;
  logic [4:0]  rg      = 5'd0;
  logic [15:0] wdata   = 16'h0;
  logic        mdio_in = 1'b1;
  logic        sel     = 1'b0;

  logic        busy_a, dv_a, err_a, mdc_a, out_a, oe_a;
  logic        busy_b, dv_b, err_b, mdc_b, out_b, oe_b;
  logic [15:0] data_a, data_b;

  mdio_master #(.MDC_DIVISOR(DIV), .PREAMBLE_BITS(32), .IDLE_BITS(1)) u_dut_a (
    .clk(clk), .i_reset_n(rst_n), .i_start(start_a), .i_clause45(c45), .i_op(op),
    .i_phy_addr(phy), .i_reg_addr(rg), .i_data(wdata), .o_busy(busy_a), .o_dv(dv_a),
    .o_data(data_a), .o_ta_err(err_a), .o_mdc(mdc_a), .o_mdio_out(out_a),
    .o_mdio_oe(oe_a), .i_mdio_in(mdio_in)
  );

  mdio_master #(.MDC_DIVISOR(DIV), .PREAMBLE_BITS(0), .IDLE_BITS(1)) u_dut_b (
    .clk(clk), .i_reset_n(rst_n), .i_start(start_b), .i_clause45(c45), .i_op(op),
    .i_phy_addr(phy), .i_reg_addr(rg), .i_data(wdata), .o_busy(busy_b), .o_dv(dv_b),
    .o_data(data_b), .o_ta_err(err_b), .o_mdc(mdc_b), .o_mdio_out(out_b),
    .o_mdio_oe(oe_b), .i_mdio_in(mdio_in)
  );

  logic        w_busy, w_dv, w_err, w_mdc, w_out, w_oe;
  logic [15:0] w_data;
  assign w_busy = sel ? busy_b : busy_a;
  assign w_dv   = sel ? dv_b   : dv_a;
  assign w_err  = sel ? err_b  : err_a;
  assign w_mdc  = sel ? mdc_b  : mdc_a;
  assign w_out  = sel ? out_b  : out_a;
  assign w_oe   = sel ? oe_b   : oe_a;
  assign w_data = sel ? data_b : data_a;

  // Wire monitor: record drive value/enable at every MDC rising edge.
  int   rise_total = 0;
  int   base       = 0;
  int   pre_len    = 32;
  bit   resp_en    = 1'b0;
  logic [15:0] resp_data = 16'h0;
  logic cap_out [0:79];
  logic cap_oe  [0:79];

  always @(posedge w_mdc) begin
    int idx;
    idx = rise_total - base;
    if (idx >= 0 && idx < 80) begin
      cap_out[idx] = w_out;
      cap_oe[idx]  = w_oe;
    end
    rise_total = rise_total + 1;
  end

  // Behavioural PHY: changes its output after MDC falls; TA bit 2 = 0 then data.
  always @(negedge w_mdc) begin
    int k;
    k = rise_total - base - pre_len;
    if (resp_en && k == 15)                mdio_in = 1'b0;
    else if (resp_en && k >= 16 && k <= 31) mdio_in = resp_data[31-k];
    else                                   mdio_in = 1'b1;
  end

  int n_pass  = 0;
  int n_total = 0;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", name, got, exp);
  endtask

  task automatic check_reset_vals(input string tag);
    check({tag, "_busy"}, 32'(w_busy), 32'd0);
    check({tag, "_dv"},   32'(w_dv),   32'd0);
    check({tag, "_data"}, 32'(w_data), 32'h0);
    check({tag, "_err"},  32'(w_err),  32'd0);
    check({tag, "_mdc"},  32'(w_mdc),  32'd0);
    check({tag, "_out"},  32'(w_out),  32'd1);
    check({tag, "_oe"},   32'(w_oe),   32'd0);
  endtask

  task automatic run_frame(input vec_t v, input string tag, input bit spam);
    int n, lat, glitch, pre;
    logic [15:0] got_data;
    logic        got_err;
    logic [31:0] fr, oe_w, mask, pre_w;
    pre = v.sel ? 0 : 32;
    @(negedge clk);
    sel = v.sel; c45 = v.c45; op = v.op; phy = v.phy; rg = v.rg; wdata = v.data;
    resp_en = v.resp_en; resp_data = v.resp; pre_len = pre; base = rise_total;
    if (v.sel) start_b = 1'b1; else start_a = 1'b1;
    @(negedge clk);
    n = 1; lat = -1; glitch = 0; got_data = 'x; got_err = 1'bx;
    while (lat < 0 && n < 1000) begin
      if (w_dv) begin
        lat = n; got_data = w_data; got_err = w_err;
      end else if (!w_busy) begin
        glitch++;
      end
      if (!spam || lat >= 0) begin
        start_a = 1'b0; start_b = 1'b0;
      end
      @(negedge clk);
      n++;
    end
    start_a = 1'b0; start_b = 1'b0;
    check({tag, "_latency"}, 32'(lat), 32'((pre + 33) * DIV + 1));
    check({tag, "_dv_pulse"}, 32'(w_dv), 32'd0);
    check({tag, "_busy_low"}, 32'(glitch), 32'd0);
    check({tag, "_data"}, 32'(got_data), 32'(v.exp_data));
    check({tag, "_ta_err"}, 32'(got_err), 32'(v.exp_err));
    for (int j = 0; j < 32; j++) begin
      fr[31-j]   = cap_out[pre+j];
      oe_w[31-j] = cap_oe[pre+j];
      pre_w[j]   = (j < pre) ? (cap_out[j] & cap_oe[j]) : 1'b1;
    end
    mask = v.is_rd ? 32'hFFFC_0000 : 32'hFFFF_FFFF;
    check({tag, "_frame"}, fr & mask, v.exp_frame & mask);
    check({tag, "_oe"}, oe_w, v.is_rd ? 32'hFFFC_0000 : 32'hFFFF_FFFF);
    if (pre > 0) check({tag, "_preamble"}, pre_w, 32'hFFFF_FFFF);
    check({tag, "_gap_oe"}, 32'(cap_oe[pre+32]), 32'd0);
    check({tag, "_mdc_periods"}, 32'(rise_total - base), 32'(pre + 33));
  endtask

  vec_t vec [0:8];

  initial begin
    int extra_dv, extra_busy;
    vec[0] = '{1'b0, 1'b0, 2'b01, 5'h01, 5'h1F, 16'h1234, 1'b0, 16'h0000, 1'b0, 32'h50FE1234, 16'h0000, 1'b0};
    vec[1] = '{1'b0, 1'b0, 2'b10, 5'h01, 5'h02, 16'h0000, 1'b1, 16'hA5A5, 1'b1, 32'h60880000, 16'hA5A5, 1'b0};
    vec[2] = '{1'b0, 1'b0, 2'b10, 5'h1F, 5'h00, 16'h0000, 1'b0, 16'h0000, 1'b1, 32'h6F800000, 16'hFFFF, 1'b1};
    vec[3] = '{1'b0, 1'b0, 2'b01, 5'h10, 5'h05, 16'hCAFE, 1'b0, 16'h0000, 1'b0, 32'h5816CAFE, 16'hFFFF, 1'b0};
    vec[4] = '{1'b1, 1'b1, 2'b00, 5'h03, 5'h01, 16'h0010, 1'b0, 16'h0000, 1'b0, 32'h01860010, 16'h0000, 1'b0};
    vec[5] = '{1'b1, 1'b1, 2'b11, 5'h03, 5'h01, 16'h0000, 1'b1, 16'hBEEF, 1'b1, 32'h31840000, 16'hBEEF, 1'b0};
    vec[6] = '{1'b1, 1'b1, 2'b10, 5'h03, 5'h01, 16'h0000, 1'b0, 16'h0000, 1'b1, 32'h21840000, 16'hFFFF, 1'b1};
    vec[7] = '{1'b0, 1'b0, 2'b11, 5'h00, 5'h00, 16'h00FF, 1'b0, 16'h0000, 1'b0, 32'h700200FF, 16'hFFFF, 1'b0};
    vec[8] = '{1'b1, 1'b1, 2'b01, 5'h03, 5'h01, 16'h5A5A, 1'b0, 16'h0000, 1'b0, 32'h11865A5A, 16'hFFFF, 1'b0};

    repeat (3) @(negedge clk);
    check_reset_vals("rst");
    check("rst_b_data", 32'(data_b), 32'h0);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    for (int i = 0; i < 9; i++) run_frame(vec[i], $sformatf("v%0d", i), 1'b0);

    // Start held high for the whole frame: exactly one completion.
    run_frame(vec[7], "spam", 1'b1);
    extra_dv = 0; extra_busy = 0;
    repeat (300) begin
      @(negedge clk);
      if (w_dv) extra_dv++;
      if (w_busy) extra_busy++;
    end
    check("spam_extra_dv", 32'(extra_dv), 32'd0);
    check("spam_extra_busy", 32'(extra_busy), 32'd0);

    // Reset in the middle of the DATA phase of a read.
    @(negedge clk);
    sel = 1'b0; c45 = 1'b0; op = 2'b10; phy = 5'h01; rg = 5'h02;
    resp_en = 1'b1; resp_data = 16'hA5A5; pre_len = 32; base = rise_total;
    start_a = 1'b1;
    @(negedge clk);
    start_a = 1'b0;
    repeat ((32 + 20) * DIV) @(negedge clk);
    check("mr_busy_before", 32'(w_busy), 32'd1);
    #2 rst_n = 1'b0;
    #1 check_reset_vals("mr");
    extra_dv = 0;
    repeat (3) begin
      @(negedge clk);
      if (w_dv) extra_dv++;
    end
    check("mr_no_dv", 32'(extra_dv), 32'd0);
    rst_n = 1'b1;
    run_frame(vec[1], "post_rst", 1'b0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached, checks %0d/%0d", n_pass, n_total);
    $fatal(1, "timeout");
  end

endmodule
